// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard receiver.
package ps2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } ps2_state_e;

    localparam logic [7:0] PS2_EXT       = 8'hE0;
    localparam logic [7:0] PS2_BRK       = 8'hF0;
    localparam logic [7:0] PS2_PAUSE     = 8'hE1;
    localparam int         PS2_DATA_BITS = 8;

endpackage

// File: rtl/ps2_filter.sv
// Two-flop synchroniser followed by a stability filter: the filtered level
// follows the synchronised input only after FILTER_CYCLES equal samples.
module ps2_filter #(
    parameter int FILTER_CYCLES = 8
) (
    input  logic clk_i,
    input  logic reset_n_i,
    input  logic raw_i,
    output logic sync_o,
    output logic filt_o
);

    localparam int CW = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES + 1) : 1;
    localparam logic [CW-1:0] RELOAD = CW'(FILTER_CYCLES - 1);

    logic          meta_q;
    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            meta_q <= 1'b1;
            sync_o <= 1'b1;
            filt_o <= 1'b1;
            cnt_q  <= RELOAD;
        end else begin
            meta_q <= raw_i;
            sync_o <= meta_q;
            // down-counter restarts whenever the input agrees with the output
            if (sync_o == filt_o) begin
                cnt_q <= RELOAD;
            end else if (cnt_q == '0) begin
                filt_o <= sync_o;
                cnt_q  <= RELOAD;
            end else begin
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end

endmodule

// File: rtl/ps2_key_rx.sv
// PS/2 keyboard frame receiver and scan-code decoder (E0/F0 prefix handling).
// Optional in-frame idle timeout enabled with `define PS2_FRAME_TIMEOUT_EN.
//
// state     | meaning
// ST_IDLE   | waiting for a start bit (sampled 0)
// ST_DATA   | shifting in 8 data bits, LSB first
// ST_PARITY | capturing the odd-parity bit
// ST_STOP   | checking stop bit, then decode or reject
module ps2_key_rx
    import ps2_pkg::*;
#(
    parameter int FILTER_CYCLES  = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic        clk_i,
    input  logic        reset_n_i,
    input  logic        ps2_clk_i,
    input  logic        ps2_data_i,
    output logic [10:0] ps2_key_o,
    output logic        err_o,
    output logic        busy_o
);

    localparam int BW = $clog2(PS2_DATA_BITS);
    localparam logic [BW-1:0] BIT_LAST = BW'(PS2_DATA_BITS - 1);

    logic clk_filt, clk_sync_unused;
    logic data_sync, data_filt_unused;
    logic clk_filt_q, fall, timeout;

    ps2_state_e  state_q, state_d;
    logic [7:0]  shift_q, shift_d;
    logic [BW-1:0] bit_cnt_q, bit_cnt_d;
    logic        par_q, par_d;
    logic        ext_q, ext_d;
    logic        rel_q, rel_d;
    logic [10:0] key_d;
    logic        err_d;

    ps2_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_clk_filter (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .raw_i     (ps2_clk_i),
        .sync_o    (clk_sync_unused),
        .filt_o    (clk_filt)
    );

    ps2_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_data_filter (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .raw_i     (ps2_data_i),
        .sync_o    (data_sync),
        .filt_o    (data_filt_unused)
    );

    assign fall   = clk_filt_q & ~clk_filt;
    assign busy_o = (state_q != ST_IDLE);

`ifdef PS2_FRAME_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TO_RELOAD = TW'(TIMEOUT_CYCLES - 1);
    logic [TW-1:0] to_cnt_q;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            to_cnt_q <= TO_RELOAD;
        end else if (state_q == ST_IDLE || fall) begin
            to_cnt_q <= TO_RELOAD;
        end else if (to_cnt_q != '0) begin
            to_cnt_q <= to_cnt_q - 1'b1;
        end
    end

    assign timeout = busy_o && !fall && (to_cnt_q == '0);
`else
    localparam int TIMEOUT_UNUSED = TIMEOUT_CYCLES;
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        par_d     = par_q;
        ext_d     = ext_q;
        rel_d     = rel_q;
        key_d     = ps2_key_o;
        err_d     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (fall && !data_sync) begin
                    state_d   = ST_DATA;
                    shift_d   = '0;
                    bit_cnt_d = BIT_LAST;
                end
            end
            ST_DATA: begin
                if (fall) begin
                    shift_d = {data_sync, shift_q[7:1]};
                    if (bit_cnt_q == '0) state_d = ST_PARITY;
                    else                 bit_cnt_d = bit_cnt_q - 1'b1;
                end
            end
            ST_PARITY: begin
                if (fall) begin
                    par_d   = data_sync;
                    state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (fall) begin
                    state_d = ST_IDLE;
                    if ((^{shift_q, par_q}) && data_sync) begin
                        if (shift_q == PS2_EXT) begin
                            ext_d = 1'b1;
                        end else if (shift_q == PS2_BRK) begin
                            rel_d = 1'b1;
                        end else if (shift_q != PS2_PAUSE) begin
                            key_d = {~ps2_key_o[10], ~rel_q, ext_q, shift_q};
                            ext_d = 1'b0;
                            rel_d = 1'b0;
                        end
                    end else begin
                        ext_d = 1'b0;
                        rel_d = 1'b0;
                        err_d = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (timeout) begin
            state_d = ST_IDLE;
            ext_d   = 1'b0;
            rel_d   = 1'b0;
            err_d   = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            clk_filt_q <= 1'b1;
            state_q    <= ST_IDLE;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            par_q      <= 1'b0;
            ext_q      <= 1'b0;
            rel_q      <= 1'b0;
            ps2_key_o  <= '0;
            err_o      <= 1'b0;
        end else begin
            clk_filt_q <= clk_filt;
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            par_q      <= par_d;
            ext_q      <= ext_d;
            rel_q      <= rel_d;
            ps2_key_o  <= key_d;
            err_o      <= err_d;
        end
    end

endmodule

// File: tb/tb_ps2_key_rx.sv
// Self-checking bench for ps2_key_rx: directed prefix/error/glitch/timeout
// scenarios plus randomized byte streams against a scan-code event model.
module tb_ps2_key_rx;

    localparam int FILT   = 8;
    localparam int TO     = 2000;
    localparam int HALF   = 20;
    localparam int SETTLE = 60;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ps2c = 1'b1;
    logic        ps2d = 1'b1;
    logic [10:0] key;
    logic        err;
    logic        busy;

    always #5 clk = ~clk;

    ps2_key_rx #(.FILTER_CYCLES(FILT), .TIMEOUT_CYCLES(TO)) dut (
        .clk_i      (clk),
        .reset_n_i  (rst_n),
        .ps2_clk_i  (ps2c),
        .ps2_data_i (ps2d),
        .ps2_key_o  (key),
        .err_o      (err),
        .busy_o     (busy)
    );

    int n_checks = 0;
    int n_fail   = 0;

    int          err_pulses = 0;
    int          err_long   = 0;
    int          events     = 0;
    int          busy_cycles = 0;
    logic        err_prev = 1'b0;
    logic [10:0] key_prev = '0;

    always @(negedge clk) begin
        if (err && !err_prev) err_pulses++;
        if (err && err_prev)  err_long++;
        if (key !== key_prev) events++;
        if (busy) busy_cycles++;
        err_prev = err;
        key_prev = key;
    end

    // reference model: key register and prefix flags
    logic [10:0] m_key = '0;
    bit          m_ext = 0;
    bit          m_rel = 0;

    task automatic model_byte(input logic [7:0] b, input bit good,
                              output int xe, output int xr);
        xe = 0;
        xr = 0;
        if (!good) begin
            m_ext = 0;
            m_rel = 0;
            xr = 1;
        end else if (b == 8'hE0) begin
            m_ext = 1;
        end else if (b == 8'hF0) begin
            m_rel = 1;
        end else if (b != 8'hE1) begin
            m_key = {~m_key[10], ~m_rel, m_ext, b};
            m_ext = 0;
            m_rel = 0;
            xe = 1;
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par,
                              input bit bad_stop, input int nbits);
        logic [10:0] bits;
        bits[0]   = 1'b0;
        bits[8:1] = b;
        bits[9]   = (~^b) ^ bad_par;
        bits[10]  = ~bad_stop;
        for (int i = 0; i < nbits; i++) begin
            ps2d = bits[i];
            repeat (HALF) @(posedge clk);
            ps2c = 1'b0;
            repeat (HALF) @(posedge clk);
            ps2c = 1'b1;
        end
        ps2d = 1'b1;
    endtask

    task automatic do_frame(input logic [7:0] b, input bit bad_par,
                            input bit bad_stop, input string tag);
        int ev0 = events;
        int er0 = err_pulses;
        int xe, xr;
        send_frame(b, bad_par, bad_stop, 11);
        repeat (SETTLE) @(posedge clk);
        @(negedge clk);
        model_byte(b, !(bad_par || bad_stop), xe, xr);
        n_checks++;
        if (key !== m_key) begin
            n_fail++;
            $display("FAIL %s key: got %h expected %h", tag, key, m_key);
        end
        n_checks++;
        if ((events - ev0) !== xe) begin
            n_fail++;
            $display("FAIL %s event_count: got %0d expected %0d", tag, events - ev0, xe);
        end
        n_checks++;
        if ((err_pulses - er0) !== xr) begin
            n_fail++;
            $display("FAIL %s err_pulses: got %0d expected %0d", tag, err_pulses - er0, xr);
        end
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s busy_after: got %b expected 0", tag, busy);
        end
    endtask

    task automatic apply_reset(input string tag);
        rst_n = 1'b0;
        ps2c  = 1'b1;
        ps2d  = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (key !== 11'h000) begin
            n_fail++;
            $display("FAIL %s reset_key: got %h expected 000", tag, key);
        end
        n_checks++;
        if (err !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s reset_err_busy: got %b%b expected 00", tag, err, busy);
        end
        m_key = '0;
        m_ext = 0;
        m_rel = 0;
        rst_n = 1'b1;
        repeat (20) @(posedge clk);
    endtask

    task automatic test_reset();
        apply_reset("reset");
    endtask

    task automatic test_basic();
        do_frame(8'h1C, 0, 0, "basic_1c");
        n_checks++;
        if (key !== 11'h61C) begin
            n_fail++;
            $display("FAIL basic_61c: got %h expected 61c", key);
        end
    endtask

    task automatic test_prefixes();
        logic t;
        t = key[10];
        do_frame(8'hF0, 0, 0, "brk_f0");
        do_frame(8'h1C, 0, 0, "brk_1c");
        n_checks++;
        if (key[9:0] !== 10'h01C || key[10] === t) begin
            n_fail++;
            $display("FAIL release_1c: got %h expected [9:0]=01c toggle!=%b", key, t);
        end
        do_frame(8'hE0, 0, 0, "ext_e0");
        do_frame(8'h75, 0, 0, "ext_75");
        n_checks++;
        if (key[9:0] !== 10'h375) begin
            n_fail++;
            $display("FAIL ext_press_75: got %h expected [9:0]=375", key[9:0]);
        end
        do_frame(8'hE0, 0, 0, "extrel_e0");
        do_frame(8'hF0, 0, 0, "extrel_f0");
        do_frame(8'h75, 0, 0, "extrel_75");
        n_checks++;
        if (key[9:0] !== 10'h175) begin
            n_fail++;
            $display("FAIL ext_release_75: got %h expected [9:0]=175", key[9:0]);
        end
        do_frame(8'hE0, 0, 0, "rep_e0a");
        do_frame(8'hE0, 0, 0, "rep_e0b");
        do_frame(8'hF0, 0, 0, "rep_f0a");
        do_frame(8'hF0, 0, 0, "rep_f0b");
        do_frame(8'hE1, 0, 0, "pause_e1");
        do_frame(8'h6B, 0, 0, "rep_6b");
        n_checks++;
        if (key[9:0] !== 10'h16B) begin
            n_fail++;
            $display("FAIL repeated_prefix: got %h expected [9:0]=16b", key[9:0]);
        end
    endtask

    task automatic test_errors();
        logic [10:0] k0;
        k0 = key;
        do_frame(8'hE0, 0, 0, "err_pre_e0");
        do_frame(8'h1C, 1, 0, "err_parity");
        n_checks++;
        if (key !== k0) begin
            n_fail++;
            $display("FAIL parity_key_hold: got %h expected %h", key, k0);
        end
        do_frame(8'h1C, 0, 0, "err_recover");
        n_checks++;
        if (key[9:0] !== 10'h21C) begin
            n_fail++;
            $display("FAIL recover_1c: got %h expected [9:0]=21c", key[9:0]);
        end
        do_frame(8'h3A, 0, 1, "err_stop");
        do_frame(8'h3A, 0, 0, "err_stop_recover");
    endtask

    task automatic test_glitch();
        int b0 = busy_cycles;
        int ev0 = events;
        ps2d = 1'b0;
        @(posedge clk);
        ps2c = 1'b0;
        repeat (3) @(posedge clk);
        ps2c = 1'b1;
        repeat (50) @(posedge clk);
        @(negedge clk);
        ps2d = 1'b1;
        n_checks++;
        if ((busy_cycles - b0) !== 0) begin
            n_fail++;
            $display("FAIL glitch_busy: got %0d busy cycles expected 0", busy_cycles - b0);
        end
        n_checks++;
        if ((events - ev0) !== 0) begin
            n_fail++;
            $display("FAIL glitch_event: got %0d events expected 0", events - ev0);
        end
        repeat (20) @(posedge clk);
    endtask

    task automatic test_random();
        logic [7:0] b;
        bit bp, bs;
        int r;
        for (int i = 0; i < 30; i++) begin
            r = $urandom_range(0, 7);
            if (r == 0)      b = 8'hE0;
            else if (r == 1) b = 8'hF0;
            else if (r == 2) b = 8'hE1;
            else             b = 8'($urandom);
            r  = $urandom_range(0, 9);
            bp = (r == 0);
            bs = (r == 1);
            do_frame(b, bp, bs, $sformatf("rand%0d_%h", i, b));
        end
    endtask

    task automatic test_back_to_back();
        do_frame(8'h1C, 0, 0, "b2b_a");
        do_frame(8'h32, 0, 0, "b2b_b");
        do_frame(8'h21, 0, 0, "b2b_c");
    endtask

    task automatic test_timeout();
        int er0;
        do_frame(8'hE0, 0, 0, "to_pre_e0");
        er0 = err_pulses;
        send_frame(8'h5A, 0, 0, 5);
        repeat (TO + 2) @(posedge clk);
        @(negedge clk);
`ifdef PS2_FRAME_TIMEOUT_EN
        n_checks++;
        if ((err_pulses - er0) !== 1) begin
            n_fail++;
            $display("FAIL timeout_err: got %0d pulses expected 1", err_pulses - er0);
        end
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_busy: got %b expected 0", busy);
        end
        m_ext = 0;
        m_rel = 0;
`else
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL no_timeout_busy: got %b expected 1", busy);
        end
        n_checks++;
        if ((err_pulses - er0) !== 0) begin
            n_fail++;
            $display("FAIL no_timeout_err: got %0d pulses expected 0", err_pulses - er0);
        end
        apply_reset("no_timeout_reset");
`endif
        do_frame(8'h29, 0, 0, "to_after_29");
        n_checks++;
        if (key[9:0] !== 10'h229) begin
            n_fail++;
            $display("FAIL timeout_then_29: got %h expected [9:0]=229", key[9:0]);
        end
    endtask

    task automatic test_reset_midframe();
        send_frame(8'h33, 0, 0, 4);
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL midframe_busy: got %b expected 1", busy);
        end
        apply_reset("midframe_reset");
        do_frame(8'h29, 0, 0, "midframe_29");
        n_checks++;
        if (key !== 11'h629) begin
            n_fail++;
            $display("FAIL midframe_629: got %h expected 629", key);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_prefixes();
        test_errors();
        test_glitch();
        test_back_to_back();
        test_random();
        test_timeout();
        test_reset_midframe();
        n_checks++;
        if (err_long !== 0) begin
            n_fail++;
            $display("FAIL err_width: got %0d over-long cycles expected 0", err_long);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
